ibex_bus_arbiter: RTL and testbench



---
 rtl/ibex_bus_arbiter.sv | 197 +++++++++++++++++++
 tb/tb_ibex_bus_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/ibex_bus_arbiter.sv
// Two-host (instruction fetch / data) to one-device arbiter using the Ibex req/gnt/rvalid protocol.
// In-order responses are steered back to the issuing host through a small ID FIFO.
module ibex_bus_arbiter #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 2,
  parameter int PRIORITY_MODE   = 0,
  localparam int BE_W           = DATA_WIDTH / 8,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  io_instr_req_i,
  input  logic [ADDR_WIDTH-1:0] io_instr_addr_i,
  output logic                  io_instr_gnt_o,
  output logic                  io_instr_rvalid_o,
  output logic [DATA_WIDTH-1:0] io_instr_rdata_o,
  output logic                  io_instr_err_o,
  input  logic                  io_data_req_i,
  input  logic                  io_data_we_i,
  input  logic [BE_W-1:0]       io_data_be_i,
  input  logic [ADDR_WIDTH-1:0] io_data_addr_i,
  input  logic [DATA_WIDTH-1:0] io_data_wdata_i,
  output logic                  io_data_gnt_o,
  output logic                  io_data_rvalid_o,
  output logic                  io_data_err_o,
  output logic [DATA_WIDTH-1:0] io_data_rdata_o,
  output logic                  io_mem_req_o,
  output logic                  io_mem_we_o,
  output logic [BE_W-1:0]       io_mem_be_o,
  output logic [ADDR_WIDTH-1:0] io_mem_addr_o,
  output logic [DATA_WIDTH-1:0] io_mem_wdata_o,
  input  logic                  io_mem_gnt_i,
  input  logic                  io_mem_rvalid_i,
  input  logic                  io_mem_err_i,
  input  logic [DATA_WIDTH-1:0] io_mem_rdata_i,
  output logic [CNT_W-1:0]      io_outstanding_o,
  output logic                  io_spurious_o
);

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);
  localparam logic ID_INSTR = 1'b0;
  localparam logic ID_DATA  = 1'b1;

  logic [MAX_OUTSTANDING-1:0] r_id_fifo;
  logic [PTR_W-1:0]           r_rd_ptr;
  logic [PTR_W-1:0]           r_wr_ptr;
  logic [CNT_W-1:0]           r_count;
  logic                       r_lock_valid;
  logic                       r_lock_id;
  logic                       r_rr_last;
  logic                       r_spurious;

  logic w_sel_id;
  logic w_sel_req;
  logic w_not_full;
  logic w_grant;
  logic w_pop;
  logic w_head_id;
  logic w_fifo_empty;

  // Circular pointer advance; depth need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] ptr);
    logic [PTR_W-1:0] nxt;
    if (ptr == PTR_LAST) begin
      nxt = {PTR_W{1'b0}};
    end else begin
      nxt = ptr + PTR_W'(1);
    end
    return nxt;
  endfunction

  // Host selection: a stalled request keeps ownership until its grant.
  always_comb begin
    w_sel_id = ID_INSTR;
    if (r_lock_valid) begin
      w_sel_id = r_lock_id;
    end else if (io_data_req_i && !io_instr_req_i) begin
      w_sel_id = ID_DATA;
    end else if (io_instr_req_i && !io_data_req_i) begin
      w_sel_id = ID_INSTR;
    end else if (io_instr_req_i && io_data_req_i) begin
      if (PRIORITY_MODE == 0) begin
        w_sel_id = ID_DATA;
      end else begin
        w_sel_id = ~r_rr_last;
      end
    end else begin
      w_sel_id = ID_INSTR;
    end
  end

  // Request mux toward the device; fetches are always full-word reads.
  always_comb begin
    w_sel_req      = 1'b0;
    io_mem_we_o    = 1'b0;
    io_mem_be_o    = {BE_W{1'b1}};
    io_mem_addr_o  = io_instr_addr_i;
    io_mem_wdata_o = {DATA_WIDTH{1'b0}};
    case (w_sel_id)
      ID_DATA: begin
        w_sel_req      = io_data_req_i;
        io_mem_we_o    = io_data_we_i;
        io_mem_be_o    = io_data_be_i;
        io_mem_addr_o  = io_data_addr_i;
        io_mem_wdata_o = io_data_wdata_i;
      end
      ID_INSTR: begin
        w_sel_req      = io_instr_req_i;
        io_mem_we_o    = 1'b0;
        io_mem_be_o    = {BE_W{1'b1}};
        io_mem_addr_o  = io_instr_addr_i;
        io_mem_wdata_o = {DATA_WIDTH{1'b0}};
      end
      default: begin
        w_sel_req      = 1'b0;
        io_mem_we_o    = 1'b0;
        io_mem_be_o    = {BE_W{1'b1}};
        io_mem_addr_o  = io_instr_addr_i;
        io_mem_wdata_o = {DATA_WIDTH{1'b0}};
      end
    endcase
  end

  assign w_fifo_empty = (r_count == {CNT_W{1'b0}});
  assign w_not_full   = (r_count < MAX_CNT);
  assign w_head_id    = r_id_fifo[r_rd_ptr];

  assign io_mem_req_o = w_sel_req & w_not_full & ~reset;
  assign w_grant      = io_mem_req_o & io_mem_gnt_i;
  assign w_pop        = io_mem_rvalid_i & ~w_fifo_empty & ~reset;

  assign io_instr_gnt_o    = w_grant & (w_sel_id == ID_INSTR);
  assign io_data_gnt_o     = w_grant & (w_sel_id == ID_DATA);
  assign io_instr_rvalid_o = w_pop & (w_head_id == ID_INSTR);
  assign io_data_rvalid_o  = w_pop & (w_head_id == ID_DATA);
  assign io_instr_rdata_o  = io_mem_rdata_i;
  assign io_data_rdata_o   = io_mem_rdata_i;
  assign io_instr_err_o    = io_mem_err_i;
  assign io_data_err_o     = io_mem_err_i;
  assign io_outstanding_o  = r_count;
  assign io_spurious_o     = r_spurious;

  // ID FIFO and in-flight count; push and pop together leave the count unchanged.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_id_fifo <= {MAX_OUTSTANDING{1'b0}};
      r_rd_ptr  <= {PTR_W{1'b0}};
      r_wr_ptr  <= {PTR_W{1'b0}};
      r_count   <= {CNT_W{1'b0}};
    end else begin
      if (w_grant) begin
        r_id_fifo[r_wr_ptr] <= w_sel_id;
        r_wr_ptr            <= ptr_next(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_next(r_rd_ptr);
      end
      case ({w_grant, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Ownership lock while the device stalls, plus round-robin history.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_lock_valid <= 1'b0;
      r_lock_id    <= ID_INSTR;
      r_rr_last    <= ID_INSTR;
    end else begin
      if (io_mem_req_o && !io_mem_gnt_i) begin
        r_lock_valid <= 1'b1;
        r_lock_id    <= w_sel_id;
      end else if (w_grant) begin
        r_lock_valid <= 1'b0;
      end
      if (w_grant) begin
        r_rr_last <= w_sel_id;
      end
    end
  end

  // Sticky flag for a response with nothing in flight.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_spurious <= 1'b0;
    end else if (io_mem_rvalid_i && w_fifo_empty) begin
      r_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ibex_bus_arbiter.sv
// Bench for ibex_bus_arbiter: directed vector table, round-robin sequence, and random traffic
// compared against a queue-based reference model for both priority modes.
module tb_ibex_bus_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic        ireq, dreq, dwe, mgnt, mrv, merr;
  logic [31:0] iaddr, daddr, dwdata, mrdata;
  logic [3:0]  dbe;

  logic [1:0]       o_igt, o_irv, o_ierr, o_dgt, o_drv, o_derr, o_mreq, o_mwe, o_spur;
  logic [1:0][31:0] o_irdata, o_drdata, o_maddr, o_mwdata;
  logic [1:0][3:0]  o_mbe;
  logic [1:0][1:0]  o_out;

  ibex_bus_arbiter #(.MAX_OUTSTANDING(2), .PRIORITY_MODE(0)) u_dut0 (
    .clock(clock), .reset(reset),
    .io_instr_req_i(ireq), .io_instr_addr_i(iaddr), .io_instr_gnt_o(o_igt[0]),
    .io_instr_rvalid_o(o_irv[0]), .io_instr_rdata_o(o_irdata[0]), .io_instr_err_o(o_ierr[0]),
    .io_data_req_i(dreq), .io_data_we_i(dwe), .io_data_be_i(dbe), .io_data_addr_i(daddr),
    .io_data_wdata_i(dwdata), .io_data_gnt_o(o_dgt[0]), .io_data_rvalid_o(o_drv[0]),
    .io_data_err_o(o_derr[0]), .io_data_rdata_o(o_drdata[0]),
    .io_mem_req_o(o_mreq[0]), .io_mem_we_o(o_mwe[0]), .io_mem_be_o(o_mbe[0]),
    .io_mem_addr_o(o_maddr[0]), .io_mem_wdata_o(o_mwdata[0]), .io_mem_gnt_i(mgnt),
    .io_mem_rvalid_i(mrv), .io_mem_err_i(merr), .io_mem_rdata_i(mrdata),
    .io_outstanding_o(o_out[0]), .io_spurious_o(o_spur[0]));

  ibex_bus_arbiter #(.MAX_OUTSTANDING(2), .PRIORITY_MODE(1)) u_dut1 (
    .clock(clock), .reset(reset),
    .io_instr_req_i(ireq), .io_instr_addr_i(iaddr), .io_instr_gnt_o(o_igt[1]),
    .io_instr_rvalid_o(o_irv[1]), .io_instr_rdata_o(o_irdata[1]), .io_instr_err_o(o_ierr[1]),
    .io_data_req_i(dreq), .io_data_we_i(dwe), .io_data_be_i(dbe), .io_data_addr_i(daddr),
    .io_data_wdata_i(dwdata), .io_data_gnt_o(o_dgt[1]), .io_data_rvalid_o(o_drv[1]),
    .io_data_err_o(o_derr[1]), .io_data_rdata_o(o_drdata[1]),
    .io_mem_req_o(o_mreq[1]), .io_mem_we_o(o_mwe[1]), .io_mem_be_o(o_mbe[1]),
    .io_mem_addr_o(o_maddr[1]), .io_mem_wdata_o(o_mwdata[1]), .io_mem_gnt_i(mgnt),
    .io_mem_rvalid_i(mrv), .io_mem_err_i(merr), .io_mem_rdata_i(mrdata),
    .io_outstanding_o(o_out[1]), .io_spurious_o(o_spur[1]));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  typedef struct {
    logic rst, ireq; logic [31:0] iaddr; logic dreq, dwe; logic [31:0] daddr;
    logic mgnt, mrv, merr; logic [31:0] rdata;
    logic e_mreq; logic [31:0] e_addr; logic e_we; logic [3:0] e_be;
    logic e_igt, e_dgt, e_irv, e_drv, e_err; logic [1:0] e_out; logic e_spur;
  } vec_t;

  function automatic vec_t mk(
    input logic rst, ireq, input logic [31:0] ia, input logic dq, we, input logic [31:0] da,
    input logic g, rv, er, input logic [31:0] rd,
    input logic e_mreq, input logic [31:0] e_addr, input logic e_we, input logic [3:0] e_be,
    input logic e_igt, e_dgt, e_irv, e_drv, e_err, input logic [1:0] e_out, input logic e_spur);
    vec_t v;
    v.rst = rst; v.ireq = ireq; v.iaddr = ia; v.dreq = dq; v.dwe = we; v.daddr = da;
    v.mgnt = g; v.mrv = rv; v.merr = er; v.rdata = rd;
    v.e_mreq = e_mreq; v.e_addr = e_addr; v.e_we = e_we; v.e_be = e_be;
    v.e_igt = e_igt; v.e_dgt = e_dgt; v.e_irv = e_irv; v.e_drv = e_drv; v.e_err = e_err;
    v.e_out = e_out; v.e_spur = e_spur;
    return v;
  endfunction

  // Reference model: a queue of host IDs in issue order (0 = instr, 1 = data).
  bit mq0[$];
  bit mq1[$];
  bit m_lockv[2], m_lockid[2], m_rr[2], m_spur[2];

  task automatic model_step(input int m);
    int  cnt;
    bit  head, sel, req, mreq, gnt, pop;
    string p;
    p    = $sformatf("rnd m%0d", m);
    cnt  = (m == 0) ? mq0.size() : mq1.size();
    head = (cnt == 0) ? 1'b0 : ((m == 0) ? mq0[0] : mq1[0]);
    if (m_lockv[m])            sel = m_lockid[m];
    else if (dreq && !ireq)    sel = 1'b1;
    else if (ireq && !dreq)    sel = 1'b0;
    else if (ireq && dreq)     sel = (m == 0) ? 1'b1 : !m_rr[m];
    else                       sel = 1'b0;
    req  = sel ? dreq : ireq;
    mreq = req && (cnt < 2) && !reset;
    gnt  = mreq && mgnt;
    pop  = mrv && (cnt > 0) && !reset;
    chk({p, " mem_req"},  32'(o_mreq[m]), 32'(mreq));
    chk({p, " instr_gnt"}, 32'(o_igt[m]), 32'(gnt && !sel));
    chk({p, " data_gnt"},  32'(o_dgt[m]), 32'(gnt && sel));
    chk({p, " instr_rv"},  32'(o_irv[m]), 32'(pop && !head));
    chk({p, " data_rv"},   32'(o_drv[m]), 32'(pop && head));
    chk({p, " outst"},     32'(o_out[m]), cnt);
    chk({p, " spurious"},  32'(o_spur[m]), 32'(m_spur[m]));
    if (mreq) begin
      chk({p, " addr"},  o_maddr[m], sel ? daddr : iaddr);
      chk({p, " we"},    32'(o_mwe[m]), 32'(sel ? dwe : 1'b0));
      chk({p, " be"},    32'(o_mbe[m]), 32'(sel ? dbe : 4'hF));
      chk({p, " wdata"}, o_mwdata[m], sel ? dwdata : 32'h0);
    end
    if (pop) begin
      chk({p, " rdata"}, head ? o_drdata[m] : o_irdata[m], mrdata);
      chk({p, " err"}, 32'(head ? o_derr[m] : o_ierr[m]), 32'(merr));
    end
    if (reset) begin
      if (m == 0) mq0.delete(); else mq1.delete();
      m_lockv[m] = 1'b0; m_rr[m] = 1'b0; m_spur[m] = 1'b0;
    end else begin
      if (pop) begin
        if (m == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
      end
      if (gnt) begin
        if (m == 0) mq0.push_back(sel); else mq1.push_back(sel);
        m_rr[m] = sel;
      end
      if (mreq && !mgnt) begin
        m_lockv[m] = 1'b1; m_lockid[m] = sel;
      end else if (gnt) begin
        m_lockv[m] = 1'b0;
      end
      if (mrv && cnt == 0) m_spur[m] = 1'b1;
    end
  endtask

  vec_t vq[$];

  initial begin
    reset = 1'b1; ireq = 1'b0; dreq = 1'b0; dwe = 1'b0; mgnt = 1'b0; mrv = 1'b0; merr = 1'b0;
    iaddr = 32'h0; daddr = 32'h0; dwdata = 32'hCAFE_0001; mrdata = 32'h0; dbe = 4'h3;
    @(posedge clock); #1;
    @(posedge clock); #1;

    //        rst ireq iaddr        dreq we daddr        g   rv  er  rdata        | mreq addr        we  be    ig  dg  irv drv err out   spur
    vq.push_back(mk(1,1,32'h100, 0,0,32'h0,   1,0,0,32'h0,        0,32'h0,  0,4'h0, 0,0,0,0,0, 2'd0,0));
    vq.push_back(mk(0,1,32'h100, 0,0,32'h0,   1,0,0,32'h0,        1,32'h100,0,4'hF, 1,0,0,0,0, 2'd0,0));
    vq.push_back(mk(0,0,32'h0,   0,0,32'h0,   0,1,0,32'hDEADBEEF, 0,32'h0,  0,4'h0, 0,0,1,0,0, 2'd1,0));
    vq.push_back(mk(0,1,32'h200, 0,0,32'h0,   1,0,0,32'h0,        1,32'h200,0,4'hF, 1,0,0,0,0, 2'd0,0));
    vq.push_back(mk(0,0,32'h0,   1,1,32'h300, 1,0,0,32'h0,        1,32'h300,1,4'h3, 0,1,0,0,0, 2'd1,0));
    vq.push_back(mk(0,1,32'h204, 0,0,32'h0,   1,1,0,32'h11111111, 0,32'h0,  0,4'h0, 0,0,1,0,0, 2'd2,0));
    vq.push_back(mk(0,1,32'h204, 0,0,32'h0,   1,1,1,32'h22222222, 1,32'h204,0,4'hF, 1,0,0,1,1, 2'd1,0));
    vq.push_back(mk(0,0,32'h0,   0,0,32'h0,   0,1,0,32'h33333333, 0,32'h0,  0,4'h0, 0,0,1,0,0, 2'd1,0));
    vq.push_back(mk(0,0,32'h0,   0,0,32'h0,   0,0,0,32'h0,        0,32'h0,  0,4'h0, 0,0,0,0,0, 2'd0,0));
    vq.push_back(mk(0,0,32'h0,   0,0,32'h0,   0,1,0,32'h44444444, 0,32'h0,  0,4'h0, 0,0,0,0,0, 2'd0,0));
    vq.push_back(mk(0,0,32'h0,   0,0,32'h0,   0,0,0,32'h0,        0,32'h0,  0,4'h0, 0,0,0,0,0, 2'd0,1));
    vq.push_back(mk(0,1,32'h400, 0,0,32'h0,   0,0,0,32'h0,        1,32'h400,0,4'hF, 0,0,0,0,0, 2'd0,1));
    vq.push_back(mk(0,1,32'h400, 1,0,32'h500, 0,0,0,32'h0,        1,32'h400,0,4'hF, 0,0,0,0,0, 2'd0,1));
    vq.push_back(mk(0,1,32'h400, 1,0,32'h500, 0,0,0,32'h0,        1,32'h400,0,4'hF, 0,0,0,0,0, 2'd0,1));
    vq.push_back(mk(0,1,32'h400, 1,0,32'h500, 1,0,0,32'h0,        1,32'h400,0,4'hF, 1,0,0,0,0, 2'd0,1));
    vq.push_back(mk(0,0,32'h0,   1,0,32'h500, 1,0,0,32'h0,        1,32'h500,0,4'h3, 0,1,0,0,0, 2'd1,1));
    vq.push_back(mk(0,0,32'h0,   1,0,32'h500, 1,0,0,32'h0,        0,32'h0,  0,4'h0, 0,0,0,0,0, 2'd2,1));
    vq.push_back(mk(0,0,32'h0,   1,0,32'h500, 1,1,0,32'h55555555, 0,32'h0,  0,4'h0, 0,0,1,0,0, 2'd2,1));
    vq.push_back(mk(0,0,32'h0,   1,0,32'h500, 0,0,0,32'h0,        1,32'h500,0,4'h3, 0,0,0,0,0, 2'd1,1));
    vq.push_back(mk(0,0,32'h0,   1,0,32'h500, 1,0,0,32'h0,        1,32'h500,0,4'h3, 0,1,0,0,0, 2'd1,1));
    vq.push_back(mk(1,0,32'h0,   1,0,32'h500, 0,1,0,32'h0,        0,32'h0,  0,4'h0, 0,0,0,0,0, 2'd2,1));
    vq.push_back(mk(0,0,32'h0,   0,0,32'h0,   0,1,0,32'h0,        0,32'h0,  0,4'h0, 0,0,0,0,0, 2'd0,0));
    vq.push_back(mk(0,0,32'h0,   0,0,32'h0,   0,0,0,32'h0,        0,32'h0,  0,4'h0, 0,0,0,0,0, 2'd0,1));
    vq.push_back(mk(0,1,32'h600, 1,1,32'h700, 1,0,0,32'h0,        1,32'h700,1,4'h3, 0,1,0,0,0, 2'd0,1));
    vq.push_back(mk(0,1,32'h600, 1,1,32'h700, 1,1,0,32'h66666666, 1,32'h700,1,4'h3, 0,1,0,1,0, 2'd1,1));
    vq.push_back(mk(0,0,32'h0,   0,0,32'h0,   0,1,1,32'h77777777, 0,32'h0,  0,4'h0, 0,0,0,1,1, 2'd1,1));
    vq.push_back(mk(0,0,32'h0,   0,0,32'h0,   0,0,0,32'h0,        0,32'h0,  0,4'h0, 0,0,0,0,0, 2'd0,1));

    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst; ireq = vq[i].ireq; iaddr = vq[i].iaddr; dreq = vq[i].dreq;
      dwe = vq[i].dwe; daddr = vq[i].daddr; mgnt = vq[i].mgnt; mrv = vq[i].mrv;
      merr = vq[i].merr; mrdata = vq[i].rdata;
      @(negedge clock);
      chk($sformatf("v%0d mem_req", i),   32'(o_mreq[0]), 32'(vq[i].e_mreq));
      chk($sformatf("v%0d instr_gnt", i), 32'(o_igt[0]),  32'(vq[i].e_igt));
      chk($sformatf("v%0d data_gnt", i),  32'(o_dgt[0]),  32'(vq[i].e_dgt));
      chk($sformatf("v%0d instr_rv", i),  32'(o_irv[0]),  32'(vq[i].e_irv));
      chk($sformatf("v%0d data_rv", i),   32'(o_drv[0]),  32'(vq[i].e_drv));
      chk($sformatf("v%0d outst", i),     32'(o_out[0]),  32'(vq[i].e_out));
      chk($sformatf("v%0d spurious", i),  32'(o_spur[0]), 32'(vq[i].e_spur));
      if (vq[i].e_mreq) begin
        chk($sformatf("v%0d addr", i), o_maddr[0], vq[i].e_addr);
        chk($sformatf("v%0d we", i),   32'(o_mwe[0]), 32'(vq[i].e_we));
        chk($sformatf("v%0d be", i),   32'(o_mbe[0]), 32'(vq[i].e_be));
      end
      if (vq[i].e_irv) begin
        chk($sformatf("v%0d instr_rdata", i), o_irdata[0], vq[i].rdata);
        chk($sformatf("v%0d instr_err", i), 32'(o_ierr[0]), 32'(vq[i].e_err));
      end
      if (vq[i].e_drv) chk($sformatf("v%0d data_err", i), 32'(o_derr[0]), 32'(vq[i].e_err));
      @(posedge clock); #1;
    end

    // Contention: mode 0 always data, mode 1 alternates D,I,D,I after reset.
    reset = 1'b1; ireq = 1'b0; dreq = 1'b0; mrv = 1'b0; merr = 1'b0;
    @(posedge clock); #1;
    reset = 1'b0; ireq = 1'b1; dreq = 1'b1; mgnt = 1'b1; iaddr = 32'h800; daddr = 32'h900;
    for (int k = 0; k < 4; k++) begin
      mrv = (k > 0);
      @(negedge clock);
      chk($sformatf("rr%0d m0 data_gnt", k), 32'(o_dgt[0]), 32'd1);
      chk($sformatf("rr%0d m0 instr_gnt", k), 32'(o_igt[0]), 32'd0);
      chk($sformatf("rr%0d m1 data_gnt", k), 32'(o_dgt[1]), 32'((k % 2) == 0));
      chk($sformatf("rr%0d m1 instr_gnt", k), 32'(o_igt[1]), 32'((k % 2) == 1));
      chk($sformatf("rr%0d m1 addr", k), o_maddr[1], ((k % 2) == 0) ? 32'h900 : 32'h800);
      @(posedge clock); #1;
    end

    // Random traffic against the reference model for both modes.
    reset = 1'b1; ireq = 1'b0; dreq = 1'b0; mgnt = 1'b0; mrv = 1'b0;
    @(posedge clock); #1;
    mq0.delete(); mq1.delete();
    for (int m = 0; m < 2; m++) begin
      m_lockv[m] = 1'b0; m_lockid[m] = 1'b0; m_rr[m] = 1'b0; m_spur[m] = 1'b0;
    end
    for (int c = 0; c < 600; c++) begin
      reset  = ($urandom_range(0, 63) == 0);
      ireq   = 1'($urandom_range(0, 1));
      dreq   = 1'($urandom_range(0, 1));
      dwe    = 1'($urandom_range(0, 1));
      dbe    = 4'($urandom_range(0, 15));
      iaddr  = $urandom;
      daddr  = $urandom;
      dwdata = $urandom;
      mgnt   = ($urandom_range(0, 9) < 6);
      mrv    = ($urandom_range(0, 9) < 4);
      merr   = 1'($urandom_range(0, 1));
      mrdata = $urandom;
      @(negedge clock);
      model_step(0);
      model_step(1);
      @(posedge clock); #1;
    end

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
